csc_multimode: RTL
==================

CSC_MULTIMODE -- requirements
Module: csc_multimode

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter DATA_W, 8, SHALL set bits per colour channel; legal range 8..12.
REQ-003 Parameter CNT_W, 24, SHALL set the width of the per-frame active-pixel counter.
REQ-004 Port clk  input  1  SHALL be the pixel clock.
REQ-005 Port rst  input  1  SHALL be the synchronous active-high reset.
REQ-006 Port i_rgb  input  3*DATA_W  SHALL carry the pixel as {R,G,B}, R in the MSBs.
REQ-007 Ports i_h_sync, i_v_sync, i_data_en  input  1 each  SHALL be the video timing signals.
REQ-008 Port i_mode  input  2  SHALL select the conversion: 0 BT.709 studio, 1 BT.601 studio, 2 BT.601 full-range, 3 bypass.
REQ-009 Port o_rgb  output  3*DATA_W  SHALL carry i_rgb delayed to match o_ycbcr.
REQ-010 Port o_ycbcr  output  3*DATA_W  SHALL carry the converted pixel as {Y,Cb,Cr}.
REQ-011 Port o_gray  output  3*DATA_W  SHALL carry {Y,Y,Y}.
REQ-012 Ports o_h_sync, o_v_sync, o_data_en  output  1 each  SHALL carry the timing signals aligned with o_ycbcr.
REQ-013 Port o_mode  output  2  SHALL show the active (latched) mode.
REQ-014 Port o_pix_cnt  output  CNT_W  SHALL show the active pixels counted since the last frame start.

Function
REQ-015 Coefficients SHALL be signed integers scaled by 256:
  - mode 0: Y(47,157,16), Cb(-26,-86,112), Cr(112,-102,-10);
  - mode 1: Y(66,129,25), Cb(-38,-74,112), Cr(112,-94,-18);
  - mode 2: Y(77,150,29), Cb(-43,-85,128), Cr(128,-107,-21).
REQ-016 Offsets SHALL be Y = 16<<(DATA_W-8) in modes 0/1 and 0 in mode 2; Cb and Cr = 128<<(DATA_W-8) in all modes; each offset SHALL be scaled by 256 before summing.
REQ-017 Each channel sum S SHALL be computed signed at DATA_W+11 bits with no intermediate overflow.
REQ-018 The output SHALL be (S+128)>>>8, clamped to 0 if negative and to 2^DATA_W-1 on overflow.
REQ-019 The pipeline SHALL be: stage 1 multiply, stage 2 partial sums, stage 3 final sum, stage 4 round/clamp register; latency from i_* to o_* SHALL be exactly 4 cycles, throughput 1 pixel/cycle, with no backpressure.
REQ-020 In mode 3, o_ycbcr SHALL equal i_rgb delayed by 4 cycles, and o_gray SHALL be {R,R,R} of that delayed pixel.
REQ-021 A frame start SHALL be a cycle where i_v_sync=1 and i_v_sync on the previous cycle was 0.
REQ-022 At a frame start, i_mode SHALL be latched into the active mode, which applies to the frame-start pixel and all later pixels.
REQ-023 A change on i_mode at any other time SHALL have no effect.
REQ-024 The active mode SHALL travel with each pixel through the pipeline, so that o_mode changes exactly 4 cycles after the latching frame start.
REQ-025 The pixel counter SHALL increment by 1 on each cycle with i_data_en=1, and SHALL hold at 2^CNT_W-1 (saturate).
REQ-026 At a frame start the counter SHALL load 1 if i_data_en=1, else 0.
REQ-027 o_pix_cnt SHALL be registered with 1-cycle latency from its input.
REQ-028 All outputs SHALL be driven from registers.

Reset
REQ-029 While rst=1, the following SHALL all be 0 on the next edge: all pipeline registers, o_rgb, o_ycbcr, o_gray, o_h_sync, o_v_sync, o_data_en, o_pix_cnt, the active mode (o_mode=0), and the previous-v_sync register.
REQ-030 rst SHALL take priority over a simultaneous frame start.
REQ-031 Pixels in flight when rst is asserted SHALL be discarded.
REQ-032 After rst is released, o_data_en SHALL remain 0 until the first i_data_en=1 has propagated through 4 cycles.

Verification
REQ-033 Mode 0, DATA_W=8, i_rgb=(255,255,255) -> o_ycbcr=(235,128,128) 4 cycles later; i_rgb=(0,0,0) -> (16,128,128).
REQ-034 Mode 1, i_rgb=(255,0,0) -> o_ycbcr=(82,90,240) 4 cycles later; o_gray=(82,82,82); o_rgb=(255,0,0).
REQ-035 Mode 2, i_rgb=(0,0,255) -> Cb saturates to 255 (raw 256), Y=29, Cr=107.
REQ-036 i_mode switched from 0 to 1 mid-frame -> conversion stays mode 0; at the next i_v_sync rise -> o_mode=1 exactly 4 cycles later, and that frame-start pixel uses mode 1.
REQ-037 Sequence of 10 pixels with i_data_en=1, then a frame start without data_en -> o_pix_cnt reaches 10, then reads 0 one cycle after the frame start; with CNT_W=4 and 20 active pixels it holds at 15.
REQ-038 rst asserted for 1 cycle mid-stream -> all outputs are 0 on the next edge, and the valid stream resumes exactly 4 cycles after the first post-reset i_data_en=1.

Source files
------------

// File: rtl/csc_multimode_if.sv
// Pixel bus for csc_multimode: timing/pixel inputs from the video source
// and the converted, timing-aligned outputs back to the sink.
interface csc_multimode_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 24
);
    logic [3*DATA_W-1:0] i_rgb;
    logic                i_h_sync;
    logic                i_v_sync;
    logic                i_data_en;
    logic [1:0]          i_mode;

    logic [3*DATA_W-1:0] o_rgb;
    logic [3*DATA_W-1:0] o_ycbcr;
    logic [3*DATA_W-1:0] o_gray;
    logic                o_h_sync;
    logic                o_v_sync;
    logic                o_data_en;
    logic [1:0]          o_mode;
    logic [CNT_W-1:0]    o_pix_cnt;

    modport master (
        output i_rgb, i_h_sync, i_v_sync, i_data_en, i_mode,
        input  o_rgb, o_ycbcr, o_gray, o_h_sync, o_v_sync, o_data_en, o_mode, o_pix_cnt
    );

    modport slave (
        input  i_rgb, i_h_sync, i_v_sync, i_data_en, i_mode,
        output o_rgb, o_ycbcr, o_gray, o_h_sync, o_v_sync, o_data_en, o_mode, o_pix_cnt
    );
endinterface

// File: rtl/csc_multimode.sv
// Four-stage RGB to YCbCr converter with per-frame mode latching (BT.709,
// BT.601 studio, BT.601 full-range, bypass) and an active-pixel counter.
module csc_multimode #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 24
) (
    input  logic           clk,
    input  logic           rst,
    csc_multimode_if.slave bus
);
    localparam int SW = DATA_W + 11;
    localparam int PW = 3 * DATA_W;
    localparam logic signed [SW-1:0] OFF_Y = SW'((16 << (DATA_W - 8)) * 256);
    localparam logic signed [SW-1:0] OFF_C = SW'((128 << (DATA_W - 8)) * 256);
    localparam logic signed [SW-1:0] RND   = SW'(128);
    localparam logic signed [SW-1:0] MAXV  = SW'((1 << DATA_W) - 1);

    logic                 r_vs_prev;
    logic [1:0]           r_mode;
    logic                 w_frame_start;
    logic [1:0]           w_mode;
    logic signed [8:0]    w_coef [9];
    logic signed [SW-1:0] w_chan [3];
    logic signed [SW-1:0] w_prod [9];

    logic signed [SW-1:0] r_s1_prod [9];
    logic signed [SW-1:0] r_s2_a [3];
    logic signed [SW-1:0] r_s2_b [3];
    logic signed [SW-1:0] r_s3_sum [3];

    logic [PW-1:0]        r_rgb_d [3];
    logic [1:0]           r_mode_d [3];
    logic                 r_hs_d [3];
    logic                 r_vs_d [3];
    logic                 r_de_d [3];

    logic signed [SW-1:0] w_sh [3];
    logic [PW-1:0]        w_ycc;
    logic [PW-1:0]        w_gray;
    logic [PW-1:0]        w_out_ycc;

    logic [PW-1:0]        r_o_rgb;
    logic [PW-1:0]        r_o_ycbcr;
    logic [PW-1:0]        r_o_gray;
    logic                 r_o_hs;
    logic                 r_o_vs;
    logic                 r_o_de;
    logic [1:0]           r_o_mode;
    logic [CNT_W-1:0]     r_cnt;

    // The frame-start pixel already uses the newly latched mode.
    assign w_frame_start = bus.i_v_sync & ~r_vs_prev;
    assign w_mode        = w_frame_start ? bus.i_mode : r_mode;

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_coef[k] = 9'sd0;
        end
        case (w_mode)
            2'd0: begin
                w_coef[0] =  9'sd47;  w_coef[1] =  9'sd157; w_coef[2] =  9'sd16;
                w_coef[3] = -9'sd26;  w_coef[4] = -9'sd86;  w_coef[5] =  9'sd112;
                w_coef[6] =  9'sd112; w_coef[7] = -9'sd102; w_coef[8] = -9'sd10;
            end
            2'd1: begin
                w_coef[0] =  9'sd66;  w_coef[1] =  9'sd129; w_coef[2] =  9'sd25;
                w_coef[3] = -9'sd38;  w_coef[4] = -9'sd74;  w_coef[5] =  9'sd112;
                w_coef[6] =  9'sd112; w_coef[7] = -9'sd94;  w_coef[8] = -9'sd18;
            end
            2'd2: begin
                w_coef[0] =  9'sd77;  w_coef[1] =  9'sd150; w_coef[2] =  9'sd29;
                w_coef[3] = -9'sd43;  w_coef[4] = -9'sd85;  w_coef[5] =  9'sd128;
                w_coef[6] =  9'sd128; w_coef[7] = -9'sd107; w_coef[8] = -9'sd21;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_chan[0] = SW'(bus.i_rgb[PW-1 -: DATA_W]);
        w_chan[1] = SW'(bus.i_rgb[2*DATA_W-1 -: DATA_W]);
        w_chan[2] = SW'(bus.i_rgb[DATA_W-1:0]);
        for (int k = 0; k < 9; k++) begin
            w_prod[k] = w_chan[k % 3] * SW'(w_coef[k]);
        end
    end

    always_comb begin
        w_ycc = '0;
        for (int c = 0; c < 3; c++) begin
            w_sh[c] = (r_s3_sum[c] + RND) >>> 8;
            if (w_sh[c][SW-1]) begin
                w_ycc[(3-c)*DATA_W-1 -: DATA_W] = '0;
            end else if (w_sh[c] > MAXV) begin
                w_ycc[(3-c)*DATA_W-1 -: DATA_W] = '1;
            end else begin
                w_ycc[(3-c)*DATA_W-1 -: DATA_W] = w_sh[c][DATA_W-1:0];
            end
        end
        if (r_mode_d[2] == 2'd3) begin
            w_out_ycc = r_rgb_d[2];
            w_gray    = {3{r_rgb_d[2][PW-1 -: DATA_W]}};
        end else begin
            w_out_ycc = w_ycc;
            w_gray    = {3{w_ycc[PW-1 -: DATA_W]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_prev <= 1'b0;
            r_mode    <= 2'd0;
            for (int k = 0; k < 9; k++) begin
                r_s1_prod[k] <= '0;
            end
            for (int c = 0; c < 3; c++) begin
                r_s2_a[c]   <= '0;
                r_s2_b[c]   <= '0;
                r_s3_sum[c] <= '0;
                r_rgb_d[c]  <= '0;
                r_mode_d[c] <= 2'd0;
                r_hs_d[c]   <= 1'b0;
                r_vs_d[c]   <= 1'b0;
                r_de_d[c]   <= 1'b0;
            end
            r_o_rgb   <= '0;
            r_o_ycbcr <= '0;
            r_o_gray  <= '0;
            r_o_hs    <= 1'b0;
            r_o_vs    <= 1'b0;
            r_o_de    <= 1'b0;
            r_o_mode  <= 2'd0;
        end else begin
            r_vs_prev <= bus.i_v_sync;
            r_mode    <= w_mode;
            for (int k = 0; k < 9; k++) begin
                r_s1_prod[k] <= w_prod[k];
            end
            // The offset joins the third product so stage 3 is a single add.
            r_s2_b[0] <= r_s1_prod[2] + ((r_mode_d[0] == 2'd2) ? '0 : OFF_Y);
            r_s2_b[1] <= r_s1_prod[5] + OFF_C;
            r_s2_b[2] <= r_s1_prod[8] + OFF_C;
            for (int c = 0; c < 3; c++) begin
                r_s2_a[c]   <= r_s1_prod[3*c] + r_s1_prod[3*c+1];
                r_s3_sum[c] <= r_s2_a[c] + r_s2_b[c];
            end
            r_rgb_d[0]  <= bus.i_rgb;
            r_mode_d[0] <= w_mode;
            r_hs_d[0]   <= bus.i_h_sync;
            r_vs_d[0]   <= bus.i_v_sync;
            r_de_d[0]   <= bus.i_data_en;
            for (int c = 1; c < 3; c++) begin
                r_rgb_d[c]  <= r_rgb_d[c-1];
                r_mode_d[c] <= r_mode_d[c-1];
                r_hs_d[c]   <= r_hs_d[c-1];
                r_vs_d[c]   <= r_vs_d[c-1];
                r_de_d[c]   <= r_de_d[c-1];
            end
            r_o_rgb   <= r_rgb_d[2];
            r_o_ycbcr <= w_out_ycc;
            r_o_gray  <= w_gray;
            r_o_hs    <= r_hs_d[2];
            r_o_vs    <= r_vs_d[2];
            r_o_de    <= r_de_d[2];
            r_o_mode  <= r_mode_d[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_frame_start) begin
            r_cnt <= CNT_W'(bus.i_data_en);
        end else if (bus.i_data_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.o_rgb     = r_o_rgb;
    assign bus.o_ycbcr   = r_o_ycbcr;
    assign bus.o_gray    = r_o_gray;
    assign bus.o_h_sync  = r_o_hs;
    assign bus.o_v_sync  = r_o_vs;
    assign bus.o_data_en = r_o_de;
    assign bus.o_mode    = r_o_mode;
    assign bus.o_pix_cnt = r_cnt;
endmodule
